instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Upstream neighbour of the RT core decode stage. Generates PCs, issues in-order reads to instruction memory and buffers returned words in a small prefetch FIFO. Presents one instruction per cycle to decode (opcode = instr[31:26]) under a valid/stall handshake. Handles branch redirects by discarding stale in-flight responses, and stops fetching once a context-switch instruction is delivered.

Parameters:
IW, 32, instruction width; opcode is instr[IW-1:IW-6]
AW, 32, PC / instruction address width (word addressed)
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2)
CTX_OPCODE, 6'b111010, opcode that halts fetch

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin fetching at start_pc (ignored unless IDLE)
start_pc  in  AW  initial PC
imem_req  out  1  read request, held only for the cycle it is issued
imem_addr  out  AW  address of request (current PC)
imem_gnt  in  1  memory accepts request this cycle (req&gnt = issued)
imem_rvalid  in  1  response valid; responses in request order, latency >=1
imem_rdata  in  IW  response word
redirect  in  1  branch taken / flush from EX
redirect_pc  in  AW  new PC
stall  in  1  decode cannot accept this cycle
instr_valid  out  1  instr/instr_pc valid to decode
instr  out  IW  instruction word (FIFO head)
instr_pc  out  AW  PC of instr
halted  out  1  high in HALT state

Behaviour:
- Reset: state IDLE, PC=0, FIFO empty, outstanding=0, drop=0; imem_req=0, instr_valid=0, halted=0, instr/instr_pc=0.
- States: IDLE -(start)-> RUN; RUN -(decode accepts instr with opcode==CTX_OPCODE)-> HALT; HALT -(start)-> RUN with PC=start_pc, FIFO/outstanding state as after reset. redirect in IDLE/HALT ignored.
- Issue (RUN only): imem_req=1 when outstanding + fifo_count < FIFO_DEPTH and no redirect this cycle. On req&gnt: PC<=PC+1, outstanding++, PC pushed to an in-order pc tag queue (depth FIFO_DEPTH).
- Response: on imem_rvalid, outstanding--; if drop>0 then drop-- and word discarded; else push {rdata, tag pc} to FIFO. Credit rule guarantees FIFO never overflows; overflow attempt is an assertion failure.
- Output: instr_valid = FIFO non-empty and state RUN and !redirect. Accept = instr_valid & !stall; pops head. Zero-bubble: simultaneous push and pop at full/empty allowed; data returned in the same cycle as rvalid is NOT bypassed (min fetch-to-decode latency = mem latency + 1).
- Redirect (priority over everything in RUN): PC<=redirect_pc, FIFO flushed, pc tag queue flushed, drop<=outstanding_next (in-flight responses, including one issued... none issued since req suppressed; includes response arriving same cycle only if not already counted). No request issued in the redirect cycle; first request next cycle.
- Redirect simultaneous with accept of CTX_OPCODE: redirect wins, stay RUN.
- HALT: no requests; remaining responses counted into drop and discarded; instr_valid=0.
- PC wraps modulo 2^AW silently.
- rst mid-operation: all state cleared; later responses to pre-reset requests are the integrator's responsibility (memory reset same cycle).

Decomposition:
- Shared package rt_core_pkg: OPC_CTX_SWITCH constant, fetch state enum (IDLE/RUN/HALT), IW/AW defaults.
- One sub-module: fetch_fifo (sync FIFO, parameter depth/width, push/pop/flush, count), instantiated twice (instruction buffer and pc tag queue).

Test Plan:
- start_pc=0x100, gnt=1, latency 1, stall=0 -> requests 0x100,0x101,... ; first instr_valid 2 cycles after first req, then one instr per cycle with instr_pc matching.
- stall held 5 cycles in steady state -> FIFO fills to 2, imem_req drops to 0, no instruction lost/duplicated; release resumes in order.
- redirect to 0x200 with 2 requests in flight (latency 3) -> both stale responses dropped, next instr_pc=0x200, instr_valid low in redirect cycle.
- Decode accepts instr with opcode 6'b111010 at pc 0x105 -> halted=1 next cycle, no further imem_req, later responses discarded; start with 0x300 resumes.
- gnt randomly deasserted, variable latency 1-4 -> delivered stream equals sequential memory image, no FIFO overflow assertion.
- rst asserted mid-RUN with FIFO full -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/rt_core_pkg.sv
// Shared definitions for the RT core front end.
// Provides the context-switch opcode, the fetch FSM state type and the default
// instruction / address widths used by the fetch unit.
package rt_core_pkg;

  localparam int unsigned IW_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT = 32;

  // Opcode (instr[IW-1:IW-6]) that stops instruction fetch once delivered to decode.
  localparam logic [5:0] OPC_CTX_SWITCH = 6'b111010;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used as the prefetch buffer and the in-order PC tag queue.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        drop all entries (wins over push/pop)
//   push_i/wdata_i write an entry; accepted when not full, or when full and popping
//   pop_i          remove the head entry (ignored when empty)
//   rdata_o        head entry
//   count_o        number of valid entries
module fetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic [Width-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [Width-1:0]               rdata_o,
  output logic [$clog2(Depth + 1)-1:0]   count_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full || do_pop);

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The producer's credit scheme must never push into a full FIFO without a pop.
  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && full && !do_pop));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit feeding the RT core decode stage.
// Generates sequential PCs, issues in-order reads to instruction memory, buffers
// returned words with their PCs in a prefetch FIFO and presents them to decode under
// a valid/stall handshake. Branch redirects flush the buffer and discard stale
// in-flight responses; delivering a context-switch opcode halts fetching.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start, start_pc            begin fetching at start_pc (from IDLE or HALT)
//   imem_req/addr/gnt          request channel; req&gnt issues a read
//   imem_rvalid/rdata          in-order response channel
//   redirect, redirect_pc      flush and restart fetch at redirect_pc
//   stall                      decode cannot accept this cycle
//   instr_valid, instr, instr_pc  head of the prefetch buffer to decode
//   halted                     fetch stopped after a context-switch instruction
module instruction_fetch_unit
  import rt_core_pkg::*;
#(
  parameter int unsigned IW         = IW_DEFAULT,
  parameter int unsigned AW         = AW_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [5:0]  CTX_OPCODE = OPC_CTX_SWITCH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          stall,
  output logic          instr_valid,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          halted
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e   state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [CW-1:0]  buf_count, tag_count;
  logic [IW+AW-1:0] buf_rdata;
  logic [AW-1:0]  tag_head;
  logic [CW:0]    credit_used;
  logic           running, issue, accept, ctx_accept;
  logic           resp_drop, resp_keep, leave_run, flush;

  assign running = (state_q == StRun);

  assign instr_valid = running && !redirect && (buf_count != '0);
  assign accept      = instr_valid && !stall;
  assign instr       = buf_rdata[IW+AW-1:AW];
  assign instr_pc    = buf_rdata[AW-1:0];
  assign ctx_accept  = accept && (instr[IW-1:IW-6] == CTX_OPCODE);

  // Every in-flight request owns a buffer slot. The entry being popped this cycle
  // frees its slot immediately, which keeps the stream at one word per cycle.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, buf_count} - {{CW{1'b0}}, accept};
  assign imem_req    = running && !redirect && (credit_used < {1'b0, CW'(FIFO_DEPTH)});
  assign imem_addr   = pc_q;
  assign issue       = imem_req && imem_gnt;

  assign resp_drop = imem_rvalid && (drop_q != '0);
  assign resp_keep = imem_rvalid && (drop_q == '0) && (tag_count != '0);

  assign leave_run = running && (redirect || ctx_accept);
  assign flush     = leave_run || (start && !running);

  assign halted = (state_q == StHalt);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
    drop_d        = resp_drop ? (drop_q - CW'(1)) : drop_q;
    case (state_q)
      StIdle, StHalt: begin
        // drop is kept: after HALT it still covers any response not yet returned.
        if (start) begin
          state_d = StRun;
          pc_d    = start_pc;
        end
      end
      StRun: begin
        if (redirect) begin
          pc_d   = redirect_pc;
          drop_d = outstanding_d;
        end else begin
          if (issue) begin
            pc_d = pc_q + AW'(1);
          end
          if (ctx_accept) begin
            state_d = StHalt;
            drop_d  = outstanding_d;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Prefetch buffer: {instruction word, PC}.
  fetch_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(IW + AW)
  ) u_instr_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (resp_keep),
    .wdata_i ({imem_rdata, tag_head}),
    .pop_i   (accept),
    .rdata_o (buf_rdata),
    .count_o (buf_count)
  );

  // PCs of live in-flight requests, in issue order.
  fetch_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(AW)
  ) u_pc_tags (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (issue),
    .wdata_i (pc_q),
    .pop_i   (resp_keep),
    .rdata_o (tag_head),
    .count_o (tag_count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: an in-order memory responder with
// configurable latency, a sequence-level model of the expected fetch/delivery stream
// checked every cycle, and directed scenarios with literal expectations.
module tb_instruction_fetch_unit;

  localparam int unsigned IW = 32;
  localparam int unsigned AW = 32;
  localparam logic [5:0]  CTX = 6'b111010;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b1;
  logic          imem_rvalid = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          stall = 1'b0;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          halted;

  instruction_fetch_unit #(
    .IW(IW),
    .AW(AW),
    .FIFO_DEPTH(2),
    .CTX_OPCODE(CTX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_pc    (start_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory image: every word carries its address; one address holds the ctx opcode.
  logic [AW-1:0] ctx_addr = 32'hFFFF_0000;
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == ctx_addr) return {CTX, a[25:0]};
    return {6'b000001, a[25:0] ^ 26'h2AA_AAAA};
  endfunction

  // In-order memory responder.
  int            lat_min = 1;
  int            lat_max = 1;
  logic [AW-1:0] rq_addr[$];
  int            rq_due[$];
  int            last_due = 0;

  always @(negedge clk) begin
    if (!rst && imem_req && imem_gnt) begin
      int due;
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq_addr.push_back(imem_addr);
      rq_due.push_back(due);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      rq_addr.delete();
      rq_due.delete();
      last_due = 0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
    end else if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = mem_word(rq_addr[0]);
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = '0;
    end
  end

  // Stream model: requests go out at consecutive addresses from the last start/redirect
  // point, decode sees consecutive PCs with their memory words, nothing while stopped.
  logic          running = 1'b0;
  logic          exp_halted = 1'b0;
  logic [AW-1:0] exp_pc = '0;
  logic [AW-1:0] exp_req_pc = '0;
  logic [IW-1:0] exp_word;
  int            delivered = 0;

  always @(negedge clk) begin
    if (rst) begin
      running = 1'b0;
      exp_halted = 1'b0;
    end else begin
      check("halted", halted, exp_halted);
      exp_word = mem_word(exp_pc);
      if (!running || redirect) begin
        check("req_quiet", imem_req, 0);
        check("valid_quiet", instr_valid, 0);
      end else begin
        if (imem_req) check("req_addr", imem_addr, exp_req_pc);
        if (instr_valid) begin
          check("instr_pc", instr_pc, exp_pc);
          check("instr_word", instr, exp_word);
        end
      end
      if (!running) begin
        if (start) begin
          running = 1'b1;
          exp_halted = 1'b0;
          exp_pc = start_pc;
          exp_req_pc = start_pc;
        end
      end else if (redirect) begin
        exp_pc = redirect_pc;
        exp_req_pc = redirect_pc;
      end else begin
        if (imem_req && imem_gnt) exp_req_pc = exp_req_pc + 1;
        if (instr_valid && !stall) begin
          delivered++;
          if (exp_word[31:26] == CTX) begin
            running = 1'b0;
            exp_halted = 1'b1;
          end
          exp_pc = exp_pc + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_delivered(input int target, input int budget, input string name);
    int n = 0;
    while (delivered < target && n < budget) begin
      tick();
      n++;
    end
    check(name, delivered >= target, 1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    @(negedge clk);
    while (!instr_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int t_req;
    int n;
    int base;

    // Reset values
    tick();
    tick();
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_addr", imem_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    // Sequential fetch, latency 1
    start_pc = 32'h100;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("first_req_addr", imem_addr, 32'h100);
    t_req = cyc;
    wait_valid(10);
    check("first_valid_latency", cyc - t_req, 2);
    check("first_instr_pc", instr_pc, 32'h100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("back_to_back_valid", instr_valid, 1);
    end

    // Stall holds the buffer full and stops requests
    tick();
    stall = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("stall_req_off", imem_req, 0);
    check("stall_valid_held", instr_valid, 1);
    tick();
    stall = 1'b0;
    wait_delivered(delivered + 6, 30, "after_stall");

    // Redirect with requests in flight (latency 3)
    lat_min = 3;
    lat_max = 3;
    repeat (8) tick();
    redirect_pc = 32'h200;
    redirect = 1'b1;
    @(negedge clk);
    check("redirect_valid_low", instr_valid, 0);
    check("redirect_req_low", imem_req, 0);
    tick();
    redirect = 1'b0;
    wait_valid(20);
    check("post_redirect_pc", instr_pc, 32'h200);

    // Context switch at 0x105 halts fetch; in-flight words discarded
    tick();
    ctx_addr = 32'h105;
    redirect_pc = 32'h103;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(instr_valid && instr_pc == 32'h105) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ctx_seen", instr_pc, 32'h105);
    @(negedge clk);
    check("halt_next", halted, 1);
    check("halt_no_req", imem_req, 0);
    n = 0;
    while (rq_due.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("halt_drained", rq_due.size(), 0);
    repeat (3) @(negedge clk);
    check("halt_valid_low", instr_valid, 0);
    tick();
    start_pc = 32'h300;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(20);
    check("restart_pc", instr_pc, 32'h300);
    tick();
    wait_delivered(delivered + 5, 40, "restart_stream");

    // Random grant and stall, latency 1..4
    lat_min = 1;
    lat_max = 4;
    base = delivered;
    for (int i = 0; i < 300; i++) begin
      imem_gnt = 1'($urandom_range(1, 0));
      stall = ($urandom_range(3, 0) == 0);
      tick();
    end
    imem_gnt = 1'b1;
    stall = 1'b0;
    wait_delivered(base + 60, 120, "random_progress");

    // PC wraps to zero
    lat_min = 1;
    lat_max = 1;
    redirect_pc = 32'hFFFF_FFFE;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    wait_delivered(delivered + 2, 20, "wrap_pre");
    wait_valid(10);
    check("wrap_pc", instr_pc, 32'h0);

    // Reset while RUN with the buffer full
    tick();
    stall = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("pre_rst_valid", instr_valid, 1);
    check("pre_rst_req_off", imem_req, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_instr", instr, 0);
    check("mid_rst_instr_pc", instr_pc, 0);
    check("mid_rst_addr", imem_addr, 0);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
